// File: rtl/wb_arbiter_rr.sv
// Round-robin N-port Wishbone master arbiter with IDLE/BUSY FSM,
// bus-error/timeout reporting, abort handling and per-port read hold.
module wb_arbiter_rr #(
  parameter int NPORTS  = 2,
  parameter int AWIDTH  = 30,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rb,
  input  logic [NPORTS-1:0]          i_req,
  input  logic [NPORTS*AWIDTH-1:0]   i_adr,
  input  logic [NPORTS-1:0]          i_we,
  input  logic [NPORTS*DWIDTH/8-1:0] i_sel,
  input  logic [NPORTS*DWIDTH-1:0]   i_dat,
  output logic [NPORTS*DWIDTH-1:0]   o_dat,
  output logic [NPORTS-1:0]          o_ack,
  output logic [NPORTS-1:0]          o_err,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_wb_we,
  output logic [DWIDTH/8-1:0]        o_wb_sel,
  output logic [31:0]                o_wb_adr,
  output logic [DWIDTH-1:0]          o_wb_dat,
  input  logic [DWIDTH-1:0]          i_wb_dat,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_err
);

  localparam int SW = DWIDTH / 8;
  localparam int GW = $clog2(NPORTS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [GW-1:0]     g;
  logic [GW-1:0]     last;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] hold [NPORTS];

  logic              req_g;
  logic              we_g;
  logic [SW-1:0]     sel_g;
  logic [AWIDTH-1:0] adr_g;
  logic [DWIDTH-1:0] dat_g;

  always_comb begin
    req_g = 1'b0;
    we_g  = 1'b0;
    sel_g = '0;
    adr_g = '0;
    dat_g = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (g == GW'(p)) begin
        req_g = i_req[p];
        we_g  = i_we[p];
        sel_g = i_sel[p*SW +: SW];
        adr_g = i_adr[p*AWIDTH +: AWIDTH];
        dat_g = i_dat[p*DWIDTH +: DWIDTH];
      end
    end
  end

  // The granted port sits out the rearbitration edge that ends its transfer.
  logic [NPORTS-1:0] mask;
  logic [GW-1:0]     nxt;
  logic              any;
  int                idx;

  always_comb begin
    mask = i_req;
    if (state == BUSY) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (g == GW'(p)) mask[p] = 1'b0;
      end
    end
    nxt = last;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = int'(last) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!any && mask[idx]) begin
        nxt = GW'(idx);
        any = 1'b1;
      end
    end
  end

  logic busy;
  logic active;
  logic ack_hit;
  logic to_hit;
  logic err_hit;
  logic term;

  assign busy    = (state == BUSY);
  assign active  = busy && req_g;
  assign ack_hit = active && i_wb_ack && !i_wb_err;
  assign to_hit  = active && !i_wb_ack && !i_wb_err &&
                   (TIMEOUT != 0) && (cnt == TMAX);
  assign err_hit = (active && i_wb_err) || to_hit;
  assign term    = ack_hit || err_hit;

  assign o_wb_cyc = active;
  assign o_wb_stb = active;
  assign o_wb_we  = busy && we_g;
  assign o_wb_sel = busy ? sel_g : '0;
  assign o_wb_adr = busy ? 32'(adr_g) : 32'd0;
  assign o_wb_dat = busy ? dat_g : '0;

  always_comb begin
    o_ack = '0;
    o_err = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (g == GW'(p)) begin
        o_ack[p] = ack_hit;
        o_err[p] = err_hit;
      end
    end
  end

  always_comb begin
    o_dat = '0;
    for (int p = 0; p < NPORTS; p++) begin
      o_dat[p*DWIDTH +: DWIDTH] = o_ack[p] ? i_wb_dat : hold[p];
    end
  end

  always_ff @(posedge i_clk or negedge i_rb) begin
    if (!i_rb) begin
      state <= IDLE;
      g     <= '0;
      last  <= GW'(NPORTS - 1);
      cnt   <= '0;
      for (int p = 0; p < NPORTS; p++) hold[p] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            g     <= nxt;
            last  <= nxt;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!req_g) begin
            state <= IDLE;
          end else if (term) begin
            if (ack_hit) hold[g] <= i_wb_dat;
            if (any) begin
              g    <= nxt;
              last <= nxt;
              cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: 4 ports, TIMEOUT=4,
// hand-computed grant order, mux values, errors, abort and reset.
module tb_wb_arbiter_rr;

  logic         clk = 1'b0;
  logic         rb;
  logic [3:0]   req;
  logic [119:0] adr;
  logic [3:0]   we;
  logic [15:0]  sel;
  logic [127:0] dat;
  logic [127:0] rdat;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic         cyc;
  logic         stb;
  logic         wwe;
  logic [3:0]   wsel;
  logic [31:0]  wadr;
  logic [31:0]  wdat;
  logic [31:0]  sdat;
  logic         sack;
  logic         serr;

  int pass_cnt = 0;
  int total    = 0;

  wb_arbiter_rr #(
    .NPORTS(4), .AWIDTH(30), .DWIDTH(32), .TIMEOUT(4)
  ) dut (
    .i_clk(clk), .i_rb(rb),
    .i_req(req), .i_adr(adr), .i_we(we),
    .i_sel(sel), .i_dat(dat),
    .o_dat(rdat), .o_ack(ack), .o_err(err),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(wwe),
    .o_wb_sel(wsel), .o_wb_adr(wadr), .o_wb_dat(wdat),
    .i_wb_dat(sdat), .i_wb_ack(sack), .i_wb_err(serr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rb = 1'b0; req = '0; adr = '0; we = '0; sel = '0; dat = '0;
    sdat = '0; sack = 1'b0; serr = 1'b0;
    #2;
    total++;
    if ({cyc, stb, wwe} !== 3'b000)
      $display("FAIL rst_ctl: got %b want 000", {cyc, stb, wwe});
    else pass_cnt++;
    total++;
    if ({wsel, wadr, wdat} !== 68'd0)
      $display("FAIL rst_bus: got %h want 0", {wsel, wadr, wdat});
    else pass_cnt++;
    total++;
    if ({ack, err} !== 8'd0)
      $display("FAIL rst_ackerr: got %b want 0", {ack, err});
    else pass_cnt++;
    total++;
    if (rdat !== 128'd0)
      $display("FAIL rst_dat: got %h want 0", rdat);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rb = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_ack [6];
    exp_ack = '{4'b0001, 4'b0010, 4'b1000,
                4'b0001, 4'b0010, 4'b1000};
    tick;
    req = 4'b1011; sack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 5) req = 4'b1000;
      #1;
      total++;
      if (stb !== 1'b1 || ack !== exp_ack[i])
        $display("FAIL rr_%0d: got stb=%b ack=%b want stb=1 ack=%b",
                 i, stb, ack, exp_ack[i]);
      else pass_cnt++;
    end
    tick;
    req = '0; sack = 1'b0;
    #1;
    total++;
    if (stb !== 1'b0)
      $display("FAIL rr_idle: got stb=%b want 0", stb);
    else pass_cnt++;
  endtask

  task automatic test_single;
    tick;
    adr[60 +: 30] = 30'h100;
    req = 4'b0100;
    #1;
    total++;
    if (stb !== 1'b0)
      $display("FAIL single_pre: got stb=%b want 0", stb);
    else pass_cnt++;
    tick;
    #1;
    total++;
    if (stb !== 1'b1 || wadr !== 32'h100 || ack !== 4'd0)
      $display("FAIL single_c1: got stb=%b adr=%h ack=%b want 1 100 0",
               stb, wadr, ack);
    else pass_cnt++;
    tick;
    tick;
    sack = 1'b1; sdat = 32'hDEADBEEF;
    #1;
    total++;
    if (ack !== 4'b0100 || rdat[64 +: 32] !== 32'hDEADBEEF)
      $display("FAIL single_ack: got ack=%b dat=%h want 0100 deadbeef",
               ack, rdat[64 +: 32]);
    else pass_cnt++;
    tick;
    req = '0; sack = 1'b0; sdat = '0;
    #1;
    total++;
    if (rdat[64 +: 32] !== 32'hDEADBEEF)
      $display("FAIL single_hold: got %h want deadbeef", rdat[64 +: 32]);
    else pass_cnt++;
    total++;
    if ({rdat[127:96], rdat[63:0]} !== 96'd0)
      $display("FAIL single_others: got %h want 0",
               {rdat[127:96], rdat[63:0]});
    else pass_cnt++;
  endtask

  task automatic test_write;
    tick;
    req = 4'b0010; we = 4'b0010;
    adr[30 +: 30] = 30'h3FFFFFFF;
    sel[4 +: 4]   = 4'b0011;
    dat[32 +: 32] = 32'h12345678;
    tick;
    #1;
    total++;
    if (stb !== 1'b1 || wwe !== 1'b1)
      $display("FAIL wr_ctl: got stb=%b we=%b want 1 1", stb, wwe);
    else pass_cnt++;
    total++;
    if (wadr !== 32'h3FFFFFFF)
      $display("FAIL wr_adr: got %h want 3fffffff", wadr);
    else pass_cnt++;
    total++;
    if (wsel !== 4'b0011 || wdat !== 32'h12345678)
      $display("FAIL wr_seldat: got %b %h want 0011 12345678",
               wsel, wdat);
    else pass_cnt++;
    sack = 1'b1; sdat = 32'hCAFE0001;
    #1;
    total++;
    if (ack !== 4'b0010)
      $display("FAIL wr_ack: got %b want 0010", ack);
    else pass_cnt++;
    tick;
    req = '0; we = '0; sack = 1'b0; sdat = '0;
    #1;
    total++;
    if (rdat[32 +: 32] !== 32'hCAFE0001)
      $display("FAIL wr_hold: got %h want cafe0001", rdat[32 +: 32]);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    tick;
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick;
      #1;
      total++;
      if (stb !== 1'b1 || ack !== 4'd0 ||
          err !== ((c == 4) ? 4'b0001 : 4'b0000))
        $display("FAIL to_c%0d: got stb=%b ack=%b err=%b", c, stb, ack, err);
      else pass_cnt++;
    end
    tick;
    #1;
    total++;
    if (stb !== 1'b0 || err !== 4'd0)
      $display("FAIL to_idle: got stb=%b err=%b want 0 0", stb, err);
    else pass_cnt++;
    req = '0;
  endtask

  task automatic test_bus_err;
    tick;
    req = 4'b0010;
    tick;
    serr = 1'b1; sack = 1'b1; sdat = 32'hFFFFFFFF;
    #1;
    total++;
    if (err !== 4'b0010 || ack !== 4'b0000)
      $display("FAIL berr_pulse: got err=%b ack=%b want 0010 0000",
               err, ack);
    else pass_cnt++;
    total++;
    if (rdat[32 +: 32] !== 32'hCAFE0001)
      $display("FAIL berr_dat: got %h want cafe0001", rdat[32 +: 32]);
    else pass_cnt++;
    tick;
    req = '0; serr = 1'b0; sack = 1'b0; sdat = '0;
    #1;
    total++;
    if (rdat[32 +: 32] !== 32'hCAFE0001)
      $display("FAIL berr_hold: got %h want cafe0001", rdat[32 +: 32]);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    tick;
    req = 4'b0001;
    tick;
    #1;
    total++;
    if (stb !== 1'b1)
      $display("FAIL ab_stb: got %b want 1", stb);
    else pass_cnt++;
    tick;
    req = '0; sack = 1'b1;
    #1;
    total++;
    if (stb !== 1'b0 || ack !== 4'd0 || err !== 4'd0)
      $display("FAIL ab_drop: got stb=%b ack=%b err=%b want 0", stb, ack, err);
    else pass_cnt++;
    tick;
    sack = 1'b0; req = 4'b0100;
    tick;
    #1;
    total++;
    if (stb !== 1'b1 || wadr !== 32'h100)
      $display("FAIL ab_next: got stb=%b adr=%h want 1 100", stb, wadr);
    else pass_cnt++;
    sack = 1'b1; sdat = 32'h0BADF00D;
    #1;
    total++;
    if (ack !== 4'b0100)
      $display("FAIL ab_ack: got %b want 0100", ack);
    else pass_cnt++;
    tick;
    req = '0; sack = 1'b0; sdat = '0;
  endtask

  task automatic test_reset_mid;
    tick;
    req = 4'b1000;
    tick;
    #1;
    total++;
    if (stb !== 1'b1)
      $display("FAIL rm_stb: got %b want 1", stb);
    else pass_cnt++;
    sack = 1'b1; rb = 1'b0;
    #1;
    total++;
    if (stb !== 1'b0 || ack !== 4'd0 || err !== 4'd0)
      $display("FAIL rm_async: got stb=%b ack=%b err=%b want 0",
               stb, ack, err);
    else pass_cnt++;
    total++;
    if (rdat !== 128'd0)
      $display("FAIL rm_hold: got %h want 0", rdat);
    else pass_cnt++;
    tick;
    rb = 1'b1; req = '0; sack = 1'b0;
    tick;
    req = 4'b1111;
    tick;
    sack = 1'b1;
    #1;
    total++;
    if (stb !== 1'b1 || ack !== 4'b0001)
      $display("FAIL rm_first: got stb=%b ack=%b want 1 0001", stb, ack);
    else pass_cnt++;
    tick;
    req = '0; sack = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_write;
    test_timeout;
    test_bus_err;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
